// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register for the ALU operands.
// Captures A, B, aluop, rd and control bits one cycle after decode,
// resolves operand forwarding at capture time, detects hazards that
// need a bubble, and honours flush/hold from the pipeline controller.
// Build option: define FWD_EN to enable the EX/MEM forwarding paths.
// Without it, every RAW dependency on an in-flight producer stalls.
module id_ex_operand_stage #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [DW-1:0]  id_a,
  input  logic [DW-1:0]  id_b,
  input  logic [DW-1:0]  id_imm,
  input  logic           id_use_imm,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic [OPW-1:0] id_aluop,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic [DW-1:0]  alu_c,
  input  logic           mem_regwrite,
  input  logic [RW-1:0]  mem_rd,
  input  logic [DW-1:0]  mem_data,
  input  logic           ex_flush,
  input  logic           ex_hold,
  output logic           stall_id,
  output logic           ex_valid,
  output logic           ex_regwrite,
  output logic           ex_memread,
  output logic [DW-1:0]  ex_a,
  output logic [DW-1:0]  ex_b,
  output logic [OPW-1:0] ex_aluop,
  output logic [RW-1:0]  ex_rd
);

  // Opcode that makes the ALU drive a cleared result; used for bubbles.
  localparam logic [OPW-1:0] ALUOP_CLR = OPW'(4'b1001);

  // A producer register matches a consumer source; r0 never matches.
  function automatic logic src_hit(input logic en,
                                   input logic [RW-1:0] rd,
                                   input logic [RW-1:0] src);
    return en && (rd != {RW{1'b0}}) && (rd == src);
  endfunction

  logic           r_valid;
  logic           r_regwrite;
  logic           r_memread;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [OPW-1:0] r_aluop;
  logic [RW-1:0]  r_rd;

  logic           w_nxt_valid;
  logic           w_nxt_regwrite;
  logic           w_nxt_memread;
  logic [DW-1:0]  w_nxt_a;
  logic [DW-1:0]  w_nxt_b;
  logic [OPW-1:0] w_nxt_aluop;
  logic [RW-1:0]  w_nxt_rd;

  logic           w_use_rt;
  logic           w_hz;
  logic [DW-1:0]  w_opa;
  logic [DW-1:0]  w_rtv;

  // rt is only a real source when B does not come from the immediate.
  assign w_use_rt = !id_use_imm;

`ifdef FWD_EN
  logic w_ex_fwd_a;
  logic w_ex_fwd_b;
  logic w_mem_fwd_a;
  logic w_mem_fwd_b;

  // Forwarding select: EX result first (loads excluded), then MEM, then RF.
  always_comb begin
    w_ex_fwd_a  = src_hit(r_valid && r_regwrite && !r_memread, r_rd, id_rs);
    w_ex_fwd_b  = src_hit(r_valid && r_regwrite && !r_memread, r_rd, id_rt);
    w_mem_fwd_a = src_hit(mem_regwrite, mem_rd, id_rs);
    w_mem_fwd_b = src_hit(mem_regwrite, mem_rd, id_rt);
    w_opa = id_a;
    w_rtv = id_b;
    if (w_ex_fwd_a) begin
      w_opa = alu_c;
    end else if (w_mem_fwd_a) begin
      w_opa = mem_data;
    end else begin
      w_opa = id_a;
    end
    if (w_ex_fwd_b) begin
      w_rtv = alu_c;
    end else if (w_mem_fwd_b) begin
      w_rtv = mem_data;
    end else begin
      w_rtv = id_b;
    end
  end

  // Only a load in EX cannot be forwarded in time: that is the hazard.
  assign w_hz = id_valid && r_valid && r_memread &&
                (src_hit(1'b1, r_rd, id_rs) ||
                 (w_use_rt && src_hit(1'b1, r_rd, id_rt)));
`else
  logic w_unused;

  assign w_opa = id_a;
  assign w_rtv = id_b;

  // With no bypass, any in-flight writer of a used source must drain first.
  assign w_hz = id_valid &&
                (src_hit(r_valid && (r_regwrite || r_memread), r_rd, id_rs) ||
                 (w_use_rt && src_hit(r_valid && (r_regwrite || r_memread), r_rd, id_rt)) ||
                 src_hit(mem_regwrite, mem_rd, id_rs) ||
                 (w_use_rt && src_hit(mem_regwrite, mem_rd, id_rt)));

  // Bypass data inputs have no consumer in this build.
  assign w_unused = ^{alu_c, mem_data};
`endif

  // A flush overrides any stall request because the ID slot is being killed.
  assign stall_id = !ex_flush && (ex_hold || w_hz);

  // Next-state selection: flush > hold > hazard bubble > capture.
  always_comb begin
    w_nxt_valid    = r_valid;
    w_nxt_regwrite = r_regwrite;
    w_nxt_memread  = r_memread;
    w_nxt_a        = r_a;
    w_nxt_b        = r_b;
    w_nxt_aluop    = r_aluop;
    w_nxt_rd       = r_rd;
    if (ex_flush || (!ex_hold && w_hz)) begin
      w_nxt_valid    = 1'b0;
      w_nxt_regwrite = 1'b0;
      w_nxt_memread  = 1'b0;
      w_nxt_a        = {DW{1'b0}};
      w_nxt_b        = {DW{1'b0}};
      w_nxt_aluop    = ALUOP_CLR;
      w_nxt_rd       = {RW{1'b0}};
    end else if (ex_hold) begin
      w_nxt_valid    = r_valid;
      w_nxt_regwrite = r_regwrite;
      w_nxt_memread  = r_memread;
      w_nxt_a        = r_a;
      w_nxt_b        = r_b;
      w_nxt_aluop    = r_aluop;
      w_nxt_rd       = r_rd;
    end else begin
      w_nxt_valid    = id_valid;
      w_nxt_regwrite = id_valid && id_regwrite;
      w_nxt_memread  = id_valid && id_memread;
      w_nxt_a        = w_opa;
      w_nxt_b        = id_use_imm ? id_imm : w_rtv;
      w_nxt_aluop    = id_aluop;
      w_nxt_rd       = id_rd;
    end
  end

  // Pipeline register with synchronous reset to the bubble state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_a        <= {DW{1'b0}};
      r_b        <= {DW{1'b0}};
      r_aluop    <= ALUOP_CLR;
      r_rd       <= {RW{1'b0}};
    end else begin
      r_valid    <= w_nxt_valid;
      r_regwrite <= w_nxt_regwrite;
      r_memread  <= w_nxt_memread;
      r_a        <= w_nxt_a;
      r_b        <= w_nxt_b;
      r_aluop    <= w_nxt_aluop;
      r_rd       <= w_nxt_rd;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_regwrite = r_regwrite;
  assign ex_memread  = r_memread;
  assign ex_a        = r_a;
  assign ex_b        = r_b;
  assign ex_aluop    = r_aluop;
  assign ex_rd       = r_rd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: ordered vector table plus
// build-specific sequences (FWD_EN selects the forwarding ones).
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        rst, v;
    logic [31:0] a, b, imm;
    logic        ui;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  op;
    logic        rw, mr;
    logic [31:0] aluc;
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        fl, ho;
  } in_t;

  typedef struct packed {
    logic        valid, rw, mr;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    logic  stall;
    out_t  o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_imm, id_regwrite, id_memread;
  logic [31:0] id_a, id_b, id_imm, alu_c, mem_data;
  logic [4:0]  id_rs, id_rt, id_rd, mem_rd;
  logic [3:0]  id_aluop;
  logic        mem_regwrite, ex_flush, ex_hold;
  logic        stall_id, ex_valid, ex_regwrite, ex_memread;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_rd;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];
  string name_q[$];
  vec_t vecs[$];
  out_t bub;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_a(id_a), .id_b(id_b),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_aluop(id_aluop), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .alu_c(alu_c), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .mem_data(mem_data), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_a(ex_a),
    .ex_b(ex_b), .ex_aluop(ex_aluop), .ex_rd(ex_rd)
  );

  function automatic in_t mk_in(input logic v, input logic [31:0] a, b, imm,
                                input logic ui, input logic [4:0] rs, rt, rd,
                                input logic [3:0] op, input logic rw, mr);
    in_t t;
    t = '0;
    t.v = v; t.a = a; t.b = b; t.imm = imm; t.ui = ui;
    t.rs = rs; t.rt = rt; t.rd = rd; t.op = op; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  function automatic out_t ov(input logic v, rw, mr, input logic [31:0] a, b,
                              input logic [3:0] op, input logic [4:0] rd);
    out_t o;
    o.valid = v; o.rw = rw; o.mr = mr; o.a = a; o.b = b; o.op = op; o.rd = rd;
    return o;
  endfunction

  function automatic vec_t mk_vec(input string n, input in_t i,
                                  input logic st, input out_t o);
    vec_t r;
    r.name = n; r.i = i; r.stall = st; r.o = o;
    return r;
  endfunction

  task automatic drive(input in_t t);
    rst = t.rst; id_valid = t.v; id_a = t.a; id_b = t.b; id_imm = t.imm;
    id_use_imm = t.ui; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
    id_aluop = t.op; id_regwrite = t.rw; id_memread = t.mr; alu_c = t.aluc;
    mem_regwrite = t.mrw; mem_rd = t.mrd; mem_data = t.md;
    ex_flush = t.fl; ex_hold = t.ho;
  endtask

  // One cycle: drive at negedge, check stall, queue expectation, check after edge.
  task automatic apply(input vec_t v);
    out_t  got, e;
    string nm;
    @(negedge clk);
    drive(v.i);
    #1;
    n_checks++;
    if (stall_id !== v.stall) begin
      n_fail++;
      $display("FAIL %s stall_id: got %b expected %b", v.name, stall_id, v.stall);
    end
    exp_q.push_back(v.o);
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    got = {ex_valid, ex_regwrite, ex_memread, ex_a, ex_b, ex_aluop, ex_rd};
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s ex_out: got v=%b rw=%b mr=%b a=%h b=%h op=%h rd=%0d expected v=%b rw=%b mr=%b a=%h b=%h op=%h rd=%0d",
               nm, got.valid, got.rw, got.mr, got.a, got.b, got.op, got.rd,
               e.valid, e.rw, e.mr, e.a, e.b, e.op, e.rd);
    end
  endtask

  initial begin
    in_t t, lw, usr;
    bub = ov(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1001, 5'd0);

    // Power-up reset.
    t = '0;
    t.rst = 1'b1;
    drive(t);
    repeat (2) @(posedge clk);

    // ---- Common vector table (identical in both builds) ----
    t = mk_in(1'b1, 32'h11, 32'h22, 32'h0, 1'b0, 5'd1, 5'd2, 5'd4, 4'd5, 1'b1, 1'b0);
    t.rst = 1'b1; t.ho = 1'b1;
    vecs.push_back(mk_vec("reset_over_hold", t, 1'b1, bub));
    t = mk_in(1'b0, 32'h1, 32'h2, 32'h0, 1'b0, 5'd6, 5'd6, 5'd6, 4'd3, 1'b1, 1'b1);
    vecs.push_back(mk_vec("idle_ctrl_forced", t, 1'b0, ov(1'b0, 1'b0, 1'b0, 32'h1, 32'h2, 4'd3, 5'd6)));
    t = mk_in(1'b1, 32'd5, 32'd7, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'b0101, 1'b1, 1'b0);
    vecs.push_back(mk_vec("capture", t, 1'b0, ov(1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 4'b0101, 5'd3)));
    for (int k = 0; k < 3; k++) begin
      t = mk_in(1'b1, 32'd9 + k, 32'd9, 32'h0, 1'b0, 5'd1, 5'd2, 5'd4, 4'd6, 1'b1, 1'b0);
      t.ho = 1'b1; t.aluc = 32'h5555; t.mrw = 1'b1; t.mrd = 5'd1; t.md = 32'h66;
      vecs.push_back(mk_vec("hold", t, 1'b1, ov(1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 4'b0101, 5'd3)));
    end
    lw = mk_in(1'b1, 32'hdeadbeef, 32'h1234, 32'hfffffff0, 1'b1, 5'd7, 5'd3, 5'd8, 4'ha, 1'b1, 1'b1);
    vecs.push_back(mk_vec("imm_sel_lw", lw, 1'b0, ov(1'b1, 1'b1, 1'b1, 32'hdeadbeef, 32'hfffffff0, 4'ha, 5'd8)));
    t = mk_in(1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 5'd4, 5'd8, 5'd9, 4'd1, 1'b1, 1'b0);
    t.fl = 1'b1;
    vecs.push_back(mk_vec("flush_with_hz", t, 1'b0, bub));
    vecs.push_back(mk_vec("recapture_lw", lw, 1'b0, ov(1'b1, 1'b1, 1'b1, 32'hdeadbeef, 32'hfffffff0, 4'ha, 5'd8)));
    usr = mk_in(1'b1, 32'h3, 32'h4, 32'h5, 1'b1, 5'd8, 5'd0, 5'd9, 4'd1, 1'b1, 1'b0);
    t = usr; t.fl = 1'b1; t.ho = 1'b1;
    vecs.push_back(mk_vec("flush_over_hold", t, 1'b0, bub));
    vecs.push_back(mk_vec("recapture_lw2", lw, 1'b0, ov(1'b1, 1'b1, 1'b1, 32'hdeadbeef, 32'hfffffff0, 4'ha, 5'd8)));
    vecs.push_back(mk_vec("load_use_rs", usr, 1'b1, bub));
    t = mk_in(1'b1, 32'h70, 32'h0, 32'h8, 1'b1, 5'd7, 5'd0, 5'd0, 4'ha, 1'b1, 1'b1);
    vecs.push_back(mk_vec("lw_to_r0", t, 1'b0, ov(1'b1, 1'b1, 1'b1, 32'h70, 32'h8, 4'ha, 5'd0)));
    t = mk_in(1'b1, 32'ha0, 32'hb0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd10, 4'd4, 1'b0, 1'b0);
    vecs.push_back(mk_vec("r0_no_hazard", t, 1'b0, ov(1'b1, 1'b0, 1'b0, 32'ha0, 32'hb0, 4'd4, 5'd10)));

    foreach (vecs[n]) apply(vecs[n]);

    // ---- Build-specific multi-cycle sequences ----
    t = mk_in(1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b1, 1'b0);
    apply(mk_vec("add_r3", t, 1'b0, ov(1'b1, 1'b1, 1'b0, 32'h1, 32'h2, 4'd0, 5'd3)));
`ifdef FWD_EN
    t = mk_in(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd5, 4'd2, 1'b1, 1'b0);
    t.aluc = 32'd12; t.mrw = 1'b1; t.mrd = 5'd3; t.md = 32'd99;
    apply(mk_vec("ex_fwd_wins", t, 1'b0, ov(1'b1, 1'b1, 1'b0, 32'd12, 32'd12, 4'd2, 5'd5)));
    t = mk_in(1'b1, 32'h60, 32'h40, 32'h0, 1'b0, 5'd6, 5'd4, 5'd0, 4'd1, 1'b1, 1'b0);
    t.aluc = 32'h55; t.mrw = 1'b1; t.mrd = 5'd4; t.md = 32'h44;
    apply(mk_vec("mem_fwd_b", t, 1'b0, ov(1'b1, 1'b1, 1'b0, 32'h60, 32'h44, 4'd1, 5'd0)));
    t = mk_in(1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0);
    t.aluc = 32'h99; t.mrw = 1'b1; t.mrd = 5'd0; t.md = 32'h88;
    apply(mk_vec("r0_not_fwd", t, 1'b0, ov(1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 4'd0, 5'd0)));
    t = mk_in(1'b1, 32'h100, 32'h0, 32'h4, 1'b1, 5'd1, 5'd0, 5'd8, 4'd0, 1'b1, 1'b1);
    apply(mk_vec("lw_r8", t, 1'b0, ov(1'b1, 1'b1, 1'b1, 32'h100, 32'h4, 4'd0, 5'd8)));
    t = mk_in(1'b1, 32'h20, 32'hbad, 32'h0, 1'b0, 5'd2, 5'd8, 5'd9, 4'd3, 1'b1, 1'b0);
    t.aluc = 32'h104;
    apply(mk_vec("load_use_rt", t, 1'b1, bub));
    t.aluc = 32'h0; t.mrw = 1'b1; t.mrd = 5'd8; t.md = 32'h77;
    apply(mk_vec("load_use_mem_fwd", t, 1'b0, ov(1'b1, 1'b1, 1'b0, 32'h20, 32'h77, 4'd3, 5'd9)));
`else
    t = mk_in(1'b1, 32'h0, 32'h4, 32'h0, 1'b0, 5'd3, 5'd4, 5'd5, 4'd2, 1'b1, 1'b0);
    t.aluc = 32'd12;
    apply(mk_vec("raw_ex_stall", t, 1'b1, bub));
    t.aluc = 32'd0; t.mrw = 1'b1; t.mrd = 5'd3; t.md = 32'd12;
    apply(mk_vec("raw_mem_stall", t, 1'b1, bub));
    t.mrw = 1'b0; t.mrd = 5'd0; t.md = 32'd0; t.a = 32'd12;
    apply(mk_vec("raw_cleared", t, 1'b0, ov(1'b1, 1'b1, 1'b0, 32'd12, 32'h4, 4'd2, 5'd5)));
    t = mk_in(1'b1, 32'h9, 32'h0, 32'h33, 1'b1, 5'd1, 5'd5, 5'd6, 4'd1, 1'b1, 1'b0);
    apply(mk_vec("rt_unused_no_raw", t, 1'b0, ov(1'b1, 1'b1, 1'b0, 32'h9, 32'h33, 4'd1, 5'd6)));
    t = mk_in(1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 5'd1, 5'd7, 5'd2, 4'd1, 1'b1, 1'b0);
    t.mrw = 1'b1; t.mrd = 5'd7; t.md = 32'h70;
    apply(mk_vec("raw_mem_rt", t, 1'b1, bub));
    t = mk_in(1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0);
    t.mrw = 1'b1; t.mrd = 5'd0; t.md = 32'h88;
    apply(mk_vec("mem_r0_no_raw", t, 1'b0, ov(1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 4'd0, 5'd0)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that feeds the 32-bit ALU its A, B and 4-bit aluop operands.
- Resolves operand forwarding from the EX and MEM stages at capture time and selects between register data and the immediate for B.
- Detects load-use hazards, inserts bubbles, and honours flush and hold requests from the pipeline controller.

Parameters:
- DW, 32, datapath width of operands and results
- RW, 5, register-address width
- OPW, 4, aluop width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  decode slot holds a real instruction
- id_a  input  DW  register-file read data for rs
- id_b  input  DW  register-file read data for rt
- id_imm  input  DW  sign/zero-extended immediate
- id_use_imm  input  1  B operand = immediate
- id_rs, id_rt, id_rd  input  RW each  source/destination register numbers
- id_aluop  input  OPW  ALU operation code
- id_regwrite, id_memread  input  1 each  control bits
- alu_c  input  DW  ALU result of the instruction currently held here
- mem_regwrite  input  1  MEM-stage write enable
- mem_rd  input  RW  MEM-stage destination
- mem_data  input  DW  MEM-stage writeback value
- ex_flush  input  1  kill the instruction entering EX
- ex_hold  input  1  downstream stall; freeze this register
- stall_id  output  1  combinational; hold PC and IF/ID
- ex_valid, ex_regwrite, ex_memread  output  1 each  registered control bits
- ex_a, ex_b  output  DW  registered ALU operands
- ex_aluop  output  OPW  registered ALU opcode
- ex_rd  output  RW  registered destination

Behaviour:
- Reset (rst=1 at posedge):
  - ex_valid=0, ex_regwrite=0, ex_memread=0, ex_a=0, ex_b=0, ex_rd=0.
  - ex_aluop=4'b1001 (ALU output clear).
  - Reset mid-hold or mid-stall discards everything.
- Latency: one cycle from ID inputs to ex_* outputs.
- Per-posedge priority: rst > ex_flush > ex_hold > load-use bubble > capture.
- Flush: next state is a bubble. A bubble is the reset values of every ex_* output. stall_id=0 while ex_flush=1.
- Hold: all ex_* registers keep their values; stall_id=1.
- Load-use hazard (hz), all of the following true:
  - ex_valid, ex_memread and id_valid are 1.
  - ex_rd!=0.
  - ex_rd==id_rs, or (ex_rd==id_rt and id_use_imm=0).
  - Response: stall_id=1 and a bubble is loaded; the ID instruction is re-presented next cycle.
- stall_id = !ex_flush && (ex_hold || hz).
- Capture: ex_valid<=id_valid; control bits, id_aluop and id_rd are copied. If id_valid=0, regwrite and memread are forced to 0.
- Forwarding, per source operand (rs for A, rt for B):
  - 1st priority, EX source: ex_valid && ex_regwrite && !ex_memread && ex_rd!=0 && ex_rd==src. Use alu_c.
  - 2nd priority, MEM source: mem_regwrite && mem_rd!=0 && mem_rd==src. Use mem_data.
  - Otherwise use the register-file value.
  - Register 0 is never forwarded.
- B selection: ex_b = id_use_imm ? id_imm : forwarded rt value.
- No arithmetic is performed here; all values pass through at full DW width.
- Simultaneous flush and hazard: the flush wins and stall_id=0.

Optional Feature:
- Macro FWD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - No forwarding paths; A and B always come from id_a and id_b (or id_imm for B).
  - hz widens to any RAW hazard: an EX-stage instruction with regwrite (load or not), or mem_regwrite, whose non-zero rd matches a used source.
  - Each widened hazard stalls one cycle and inserts one bubble, repeating until the producer clears.

Test Plan:
- Reset, then idle with id_valid=0 -> ex_valid=0, ex_aluop=4'b1001, ex_a=ex_b=0, stall_id=0.
- Capture: id_a=5, id_b=7, aluop=4'b0101, rd=3 -> next cycle ex_a=5, ex_b=7, ex_aluop=4'b0101, ex_rd=3, ex_valid=1.
- EX forward (FWD_EN): held add to r3, alu_c=12; next instruction has rs=3 and id_a=0 -> ex_a=12. If mem_rd=3 and mem_data=99 at the same time -> still 12 (EX wins).
- Load-use: held lw with ex_rd=8; ID instruction has rt=8, use_imm=0 -> stall_id=1, bubble loaded, instruction captured one cycle later with mem_data forwarded.
- ex_flush=1 together with a load-use hazard -> bubble loaded, stall_id=0. Then ex_hold=1 for 3 cycles -> outputs frozen, stall_id=1.
- Build without FWD_EN: add r3 followed by an instruction using r3 -> stall_id=1 for 2 cycles, then ex_a=mem_data register value via id_a.
